// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and sizing helpers for the sample FIFO
package fifo_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    // Pointer width for a given depth; never below 1 so tiny depths still index.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - simple dual-port RAM, registered or combinational read port
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int FWFT  = FWFT_OFF,
    localparam int AW   = addr_width(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    generate
        if (FWFT == FWFT_ON) begin : g_comb_rd
            logic unused_rd;
            assign unused_rd = i_rd_en ^ i_rst_n;
            assign o_rd_data = mem_q[i_rd_addr];
        end else begin : g_reg_rd
            logic [WIDTH-1:0] rd_data_q;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    rd_data_q <= '0;
                end else if (i_rd_en) begin
                    rd_data_q <= mem_q[i_rd_addr];
                end
            end
            assign o_rd_data = rd_data_q;
        end
    endgenerate

endmodule

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - single-clock FIFO with level flags, sticky errors and optional FWFT read
module sample_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 2,
    parameter int FWFT       = FWFT_OFF,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_wr_inc,
    input  logic [WIDTH-1:0] i_datain,
    input  logic             i_rd_inc,
    output logic [WIDTH-1:0] o_dataout,
    output logic             o_rd_valid,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_almost_full,
    output logic             o_almost_empty,
    output logic [CW-1:0]    o_count,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam int AW = addr_width(DEPTH);

    generate
        if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
            $error("sample_fifo: DEPTH must be a power of two and at least 4");
        end
        if (AFULL_LVL > DEPTH) begin : g_bad_afull
            $error("sample_fifo: AFULL_LVL must not exceed DEPTH");
        end
        if (AEMPTY_LVL >= AFULL_LVL) begin : g_bad_aempty
            $error("sample_fifo: AEMPTY_LVL must be below AFULL_LVL");
        end
    endgenerate

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          full, empty;
    logic          wr_acc, rd_acc;
    logic          mem_wr_en, mem_rd_en;
    logic [WIDTH-1:0] mem_rd_data;

    // Every flag is a decode of the registered count, so all move together.
    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign wr_acc = i_wr_inc & ~full;
    assign rd_acc = i_rd_inc & ~empty;

    assign mem_wr_en = wr_acc & ~i_flush;
    assign mem_rd_en = rd_acc & ~i_flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (i_flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            overflow_d  = overflow_q  | (i_wr_inc & full);
            underflow_d = underflow_q | (i_rd_inc & empty);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .FWFT  (FWFT)
    ) u_mem (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (mem_wr_en),
        .i_wr_addr (wr_ptr_q),
        .i_wr_data (i_datain),
        .i_rd_en   (mem_rd_en),
        .i_rd_addr (rd_ptr_q),
        .o_rd_data (mem_rd_data)
    );

    generate
        if (FWFT == FWFT_ON) begin : g_fwft
            // Mask stale RAM content so an empty or reset FIFO shows zero.
            assign o_dataout  = empty ? '0 : mem_rd_data;
            assign o_rd_valid = ~empty;
        end else begin : g_std
            logic rd_valid_q;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= mem_rd_en;
                end
            end
            assign o_dataout  = mem_rd_data;
            assign o_rd_valid = rd_valid_q;
        end
    endgenerate

    assign o_full         = full;
    assign o_empty        = empty;
    assign o_almost_full  = (count_q >= CW'(AFULL_LVL));
    assign o_almost_empty = (count_q <= CW'(AEMPTY_LVL));
    assign o_count        = count_q;
    assign o_overflow     = overflow_q;
    assign o_underflow    = underflow_q;

endmodule
